fabric_conf_ctrl: RTL and testbench

- Configuration sequencer for the 5x5 overlay's switch and tile fabric.
- Accepts configuration words from the host-side bridge over a valid/ready stream and serialises them, LSB first, onto the fabric's shared config chain (conf_en plus one data bit per cycle).
- Counts chain bits, holds the fabric out of run mode while loading, and raises done/fabric_run when exactly CHAIN_BITS bits have been shifted.

---
 rtl/fabric_conf_ctrl_pkg.sv | 16 +
 rtl/conf_piso.sv | 41 ++++
 rtl/fabric_conf_ctrl.sv | 105 ++++++++++
 tb/tb_fabric_conf_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fabric_conf_ctrl_pkg.sv
// Shared constants and FSM encoding for the 5x5 overlay configuration sequencer.
// Default sizes match the full 5x5 fabric chain.
package fabric_conf_ctrl_pkg;

    localparam int CONF_WORD_W     = 32;
    localparam int CONF_CHAIN_BITS = 1024;
    localparam int CONF_CNT_W      = 16;

    typedef enum logic [1:0] {
        CS_IDLE  = 2'd0,
        CS_WAIT  = 2'd1,
        CS_SHIFT = 2'd2,
        CS_DONE  = 2'd3
    } conf_state_t;

endpackage

// File: rtl/conf_piso.sv
// Parallel-load, shift-right word register feeding the config chain LSB first.
// It also tracks the bit position within the current word.
module conf_piso #(
    parameter int WORD_W = 32,
    parameter int WB_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] din,
    output logic              dout,
    output logic              last_bit
);

    logic [WORD_W-1:0] shreg;
    logic [WB_W-1:0]   wb;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
            wb    <= '0;
        end else if (clear) begin
            shreg <= '0;
            wb    <= '0;
        end else if (load) begin
            shreg <= din;
            wb    <= '0;
        end else if (shift) begin
            shreg <= shreg >> 1;
            wb    <= wb + WB_W'(1);
        end
    end

    assign dout     = shreg[0];
    assign last_bit = (wb == WB_W'(WORD_W - 1));

endmodule

// File: rtl/fabric_conf_ctrl.sv
// Configuration sequencer: takes host words over valid/ready, shifts them onto the
// fabric config chain, and releases the fabric into run mode once the chain is full.
module fabric_conf_ctrl
    import fabric_conf_ctrl_pkg::*;
#(
    parameter int WORD_W     = CONF_WORD_W,
    parameter int CHAIN_BITS = CONF_CHAIN_BITS,
    parameter int CNT_W      = CONF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              conf_en,
    output logic              conf_bit,
    output logic              busy,
    output logic              done,
    output logic              fabric_run,
    output logic              err,
    output logic [CNT_W-1:0]  bit_cnt
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_BITS - 1);

    conf_state_t      state;
    conf_state_t      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             err_q;
    logic             loading;
    logic             idle_like;
    logic             accept;
    logic             shifting;
    logic             word_last;
    logic             piso_bit;

    assign loading   = (state == CS_WAIT) || (state == CS_SHIFT);
    assign idle_like = (state == CS_IDLE) || (state == CS_DONE);
    // An abort cancels the handshake even though cfg_ready is a pure state decode.
    assign accept    = (state == CS_WAIT) && cfg_valid && !abort;
    assign shifting  = (state == CS_SHIFT) && !abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= CS_IDLE;
        else      state <= state_nxt;
    end

    // NOTE: next state defaults to the current state first so no path through
    // the case leaves it unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            CS_IDLE, CS_DONE: begin
                if (start) state_nxt = CS_WAIT;
            end
            CS_WAIT: begin
                if (abort)          state_nxt = CS_IDLE;
                else if (cfg_valid) state_nxt = CS_SHIFT;
            end
            CS_SHIFT: begin
                if (abort)                 state_nxt = CS_IDLE;
                else if (cnt == LAST_CNT)  state_nxt = CS_DONE;
                else if (word_last)        state_nxt = CS_WAIT;
            end
            default: state_nxt = CS_IDLE;
        endcase
    end

    // Counter holds its partial value on abort so a failed load can be inspected.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= loading && start && !abort;
            if (idle_like && start) cnt <= '0;
            else if (shifting)      cnt <= cnt + CNT_W'(1);
        end
    end

    conf_piso #(
        .WORD_W(WORD_W)
    ) u_piso (
        .clk     (clk),
        .rst     (rst),
        .clear   (loading && abort),
        .load    (accept),
        .shift   (shifting),
        .din     (cfg_data),
        .dout    (piso_bit),
        .last_bit(word_last)
    );

    assign cfg_ready  = (state == CS_WAIT);
    assign conf_en    = (state == CS_SHIFT);
    assign conf_bit   = piso_bit;
    assign busy       = loading;
    assign done       = (state == CS_DONE);
    assign fabric_run = (state == CS_DONE);
    assign err        = err_q;
    assign bit_cnt    = cnt;

endmodule

// File: tb/tb_fabric_conf_ctrl.sv
// Self-checking bench: two chain sizes (40 and 64 bits) share one stimulus; the
// expected chain stream is built from the host words, truncated to the chain length.
module tb_fabric_conf_ctrl;

    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [31:0] cfg_data = '0;
    logic        sel64 = 1'b0;

    logic r40, e40, b40, bu40, d40, f40, er40;
    logic r64, e64, b64, bu64, d64, f64, er64;
    logic [15:0] c40, c64;

    fabric_conf_ctrl #(.WORD_W(32), .CHAIN_BITS(40), .CNT_W(16)) dut40 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_data(cfg_data),
        .cfg_valid(cfg_valid), .cfg_ready(r40), .conf_en(e40), .conf_bit(b40),
        .busy(bu40), .done(d40), .fabric_run(f40), .err(er40), .bit_cnt(c40));

    fabric_conf_ctrl #(.WORD_W(32), .CHAIN_BITS(64), .CNT_W(16)) dut64 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_data(cfg_data),
        .cfg_valid(cfg_valid), .cfg_ready(r64), .conf_en(e64), .conf_bit(b64),
        .busy(bu64), .done(d64), .fabric_run(f64), .err(er64), .bit_cnt(c64));

    logic        o_ready, o_en, o_bit, o_busy, o_done, o_run, o_err;
    logic [15:0] o_cnt;
    assign o_ready = sel64 ? r64  : r40;
    assign o_en    = sel64 ? e64  : e40;
    assign o_bit   = sel64 ? b64  : b40;
    assign o_busy  = sel64 ? bu64 : bu40;
    assign o_done  = sel64 ? d64  : d40;
    assign o_run   = sel64 ? f64  : f40;
    assign o_err   = sel64 ? er64 : er40;
    assign o_cnt   = sel64 ? c64  : c40;

    always #5 clk = ~clk;

    // Observed chain traffic, word handshakes and done rises, sampled mid-cycle.
    int   cyc = 0;
    bit   en_bits[$];
    int   en_cyc[$];
    int   acc_cyc[$];
    int   done_cyc[$];
    logic prev_done = 1'b0;

    always @(negedge clk) begin
        if (o_en) begin
            en_bits.push_back(o_bit);
            en_cyc.push_back(cyc);
        end
        if (o_ready && cfg_valid && !abort) acc_cyc.push_back(cyc);
        if (o_done && !prev_done) done_cyc.push_back(cyc);
        prev_done <= o_done;
        cyc <= cyc + 1;
    end

    int          checks = 0;
    int          errors = 0;
    logic [31:0] words [4];
    int          b_en, b_acc, b_done;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        start = 0; abort = 0; cfg_valid = 0;
        rst = 0;
        tick(); tick();
        rst = 1;
        tick();
    endtask

    task automatic wait_cnt(input int target);
        int n = 0;
        while (o_cnt != 16'(target) && n < 200) begin tick(); n++; end
        checks++;
        if (n >= 200) begin errors++; $display("FAIL wait_cnt: bit_cnt=%0d never reached %0d", o_cnt, target); end
    endtask

    task automatic begin_load();
        b_en = en_bits.size(); b_acc = acc_cyc.size(); b_done = done_cyc.size();
        start = 1; tick(); start = 0;
        checks++;
        if ({o_busy, o_ready, o_done, o_run, o_cnt} !== {4'b1100, 16'd0}) begin
            errors++;
            $display("FAIL load_start: busy/ready/done/run/cnt=%b/%b/%b/%b/%0d want 1/1/0/0/0", o_busy, o_ready, o_done, o_run, o_cnt);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap, input int exp_cnt);
        int n = 0;
        if (gap > 0) begin
            cfg_valid = 0;
            while (!o_ready && n < 200) begin tick(); n++; end
            repeat (gap) begin
                checks++;
                if (o_en !== 1'b0 || o_cnt !== 16'(exp_cnt)) begin
                    errors++;
                    $display("FAIL gap_hold: conf_en=%b bit_cnt=%0d want 0/%0d", o_en, o_cnt, exp_cnt);
                end
                tick();
            end
        end
        cfg_data = w; cfg_valid = 1;
        while (!o_ready && n < 200) begin tick(); n++; end
        checks++;
        if (n >= 200) begin errors++; $display("FAIL word_accept: cfg_ready=%b want 1 within budget", o_ready); end
        tick();
    endtask

    task automatic finish_load(input int chain, input int gap_at, input int gap_len);
        int n = 0;
        int nw = (chain + W - 1) / W;
        int got, mm, d, want;
        bit ready_seen = 0;
        cfg_data = $urandom;
        while (!o_done && n < chain + 100) begin
            if (o_ready) ready_seen = 1;
            tick(); n++;
        end
        cfg_valid = 0;
        checks++;
        if (n >= chain + 100) begin errors++; $display("FAIL done_timeout: done=%b want 1", o_done); end
        checks++;
        if (ready_seen) begin errors++; $display("FAIL extra_ready: cfg_ready=1 seen after last word, want 0"); end
        tick(); tick();
        got = en_bits.size() - b_en;
        checks++;
        if (got != chain) begin errors++; $display("FAIL en_cycles: got %0d want %0d", got, chain); end
        checks++;
        if (acc_cyc.size() - b_acc != nw) begin
            errors++; $display("FAIL words_used: got %0d want %0d", acc_cyc.size() - b_acc, nw);
        end
        if (got == chain && acc_cyc.size() - b_acc == nw) begin
            mm = 0;
            for (int i = 0; i < chain; i++)
                if (en_bits[b_en + i] !== words[i / W][i % W]) mm++;
            checks++;
            if (mm != 0) begin errors++; $display("FAIL bit_stream: %0d bits wrong, want 0", mm); end
            checks++;
            if (en_cyc[b_en] - acc_cyc[b_acc] != 1) begin
                errors++; $display("FAIL first_bit_latency: got %0d want 1", en_cyc[b_en] - acc_cyc[b_acc]);
            end
            for (int k = 1; k < nw; k++) begin
                d = en_cyc[b_en + W * k] - en_cyc[b_en + W * k - 1];
                want = 2 + ((k == gap_at) ? gap_len : 0);
                checks++;
                if (d != want) begin errors++; $display("FAIL word_bubble%0d: spacing %0d want %0d", k, d, want); end
            end
            checks++;
            if (done_cyc.size() <= b_done) begin
                errors++; $display("FAIL done_timing: no done rise, want one");
            end else if (done_cyc[b_done] != en_cyc[b_en + chain - 1] + 1) begin
                errors++; $display("FAIL done_timing: rise at %0d want %0d", done_cyc[b_done], en_cyc[b_en + chain - 1] + 1);
            end
        end
        checks++;
        if ({o_done, o_run, o_busy, o_en, o_ready, o_cnt} !== {5'b11000, 16'(chain)}) begin
            errors++;
            $display("FAIL done_state: done/run/busy/en/ready/cnt=%b/%b/%b/%b/%b/%0d want 1/1/0/0/0/%0d",
                     o_done, o_run, o_busy, o_en, o_ready, o_cnt, chain);
        end
    endtask

    task automatic run_load(input int chain, input int gap_at, input int gap_len);
        int nw = (chain + W - 1) / W;
        begin_load();
        for (int k = 0; k < nw; k++)
            send_word(words[k], (k == gap_at) ? gap_len : 0, W * k);
        finish_load(chain, gap_at, gap_len);
    endtask

    task automatic randomize_words();
        for (int k = 0; k < 4; k++) words[k] = $urandom;
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if ({r40, e40, b40, bu40, d40, f40, er40, c40} !== '0) begin
            errors++; $display("FAIL reset40: outputs=%b want all 0", {r40, e40, b40, bu40, d40, f40, er40, c40});
        end
        checks++;
        if ({r64, e64, b64, bu64, d64, f64, er64, c64} !== '0) begin
            errors++; $display("FAIL reset64: outputs=%b want all 0", {r64, e64, b64, bu64, d64, f64, er64, c64});
        end
        rst = 1;
        tick();
    endtask

    task automatic test_basic();
        words[0] = 32'hA5A5_A5A5;
        words[1] = 32'h0000_00FF;
        run_load(40, -1, 0);
    endtask

    task automatic test_backpressure();
        randomize_words();
        run_load(40, 1, 7);
    endtask

    task automatic test_abort();
        int pos [2];
        pos[0] = 17;
        pos[1] = $urandom_range(1, 38);
        for (int p = 0; p < 2; p++) begin
            randomize_words();
            begin_load();
            send_word(words[0], 0, 0);
            if (pos[p] >= W) send_word(words[1], 0, W);
            cfg_valid = 0;
            wait_cnt(pos[p]);
            abort = 1; tick(); abort = 0;
            repeat (2) begin
                checks++;
                if ({o_en, o_busy, o_done, o_run, o_ready, o_cnt} !== {5'b00000, 16'(pos[p])}) begin
                    errors++;
                    $display("FAIL abort_idle: en/busy/done/run/ready/cnt=%b/%b/%b/%b/%b/%0d want 0/0/0/0/0/%0d",
                             o_en, o_busy, o_done, o_run, o_ready, o_cnt, pos[p]);
                end
                tick();
            end
            randomize_words();
            run_load(40, -1, 0);
        end
        // Abort in the same cycle as a presented word: the word must not load.
        begin_load();
        cfg_data = $urandom; cfg_valid = 1; abort = 1;
        tick();
        abort = 0; cfg_valid = 0;
        tick();
        checks++;
        if ({o_busy, o_en, o_cnt} !== '0) begin
            errors++; $display("FAIL abort_vs_valid: busy/en/cnt=%b/%b/%0d want 0/0/0", o_busy, o_en, o_cnt);
        end
    endtask

    task automatic test_start_busy();
        randomize_words();
        begin_load();
        send_word(words[0], 0, 0);
        wait_cnt(5);
        start = 1; tick(); start = 0;
        checks++;
        if (o_err !== 1'b1) begin errors++; $display("FAIL err_pulse: err=%b want 1", o_err); end
        tick();
        checks++;
        if (o_err !== 1'b0 || o_busy !== 1'b1) begin
            errors++; $display("FAIL err_width: err/busy=%b/%b want 0/1", o_err, o_busy);
        end
        send_word(words[1], 0, W);
        finish_load(40, -1, 0);

        begin_load();
        send_word($urandom, 0, 0);
        repeat (3) tick();
        start = 1; abort = 1; tick(); start = 0; abort = 0;
        checks++;
        if ({o_busy, o_en, o_err, o_done} !== 4'b0000) begin
            errors++; $display("FAIL start_abort: busy/en/err/done=%b/%b/%b/%b want 0/0/0/0", o_busy, o_en, o_err, o_done);
        end
    endtask

    task automatic test_reconfig();
        randomize_words();
        run_load(40, -1, 0);
        randomize_words();
        run_load(40, -1, 0);
        begin_load();
        send_word(words[0], 0, 0);
        repeat (3) tick();
        #2 rst = 0;
        #1;
        checks++;
        if ({o_ready, o_en, o_bit, o_busy, o_done, o_run, o_err, o_cnt} !== '0) begin
            errors++; $display("FAIL async_reset: outputs=%b want all 0",
                               {o_ready, o_en, o_bit, o_busy, o_done, o_run, o_err, o_cnt});
        end
        tick();
        cfg_valid = 0;
        rst = 1;
        tick();
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            sel64 = ($urandom_range(0, 1) == 1);
            apply_reset();
            randomize_words();
            run_load(sel64 ? 64 : 40, 1, $urandom_range(0, 9));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_abort();
        test_start_busy();
        test_reconfig();
        sel64 = 1;
        apply_reset();
        randomize_words();
        run_load(64, -1, 0);
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
